fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage: owns the PC, drives the instruction-memory request port and presents
//  {if_pc_read_data, if_instruction} to the IF/ID pipeline register (producer side of IF/ID).
//  Honours stall[0] from the stall controller and raises stall_request_from_if while a fetch is outstanding.
//  Accepts branch redirects from ID with MIPS delay-slot semantics.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] must be 0
//  NOP_WORD   32'h0000_0000  value on if_instruction when no valid word is held
// PORTS
//  clock                  in   1   rising-edge clock
//  reset                  in   1   synchronous, active-high (RESET_ENABLE = 1'b1)
//  stall                  in   6   stall vector from stall controller; only stall[0] is used here
//  branch_flag            in   1   one-cycle pulse from ID: take branch_target after the delay slot
//  branch_target          in   32  redirect address; bits [1:0] are forced to 0
//  imem_req               out  1   fetch request, held high until imem_ack
//  imem_addr              out  32  fetch address (= pc), stable while imem_req high
//  imem_ack               in   1   memory returns imem_rdata this cycle (0..N cycles after req)
//  imem_rdata             in   32  fetched word, valid only with imem_ack
//  if_pc_read_data        out  32  PC of the word presented to IF/ID
//  if_instruction         out  32  word presented to IF/ID (NOP_WORD when none valid)
//  stall_request_from_if  out  1   high when IF has no valid word to hand over
// BEHAVIOUR
//  State: S_IDLE, S_REQ, S_HOLD. Registers: pc, inst_buf, valid, pend_flag, pend_target.
//  Reset (sync): state=S_IDLE, pc=RESET_PC, inst_buf=NOP_WORD, valid=0, pend_flag=0, pend_target=0.
//    Reset outputs: imem_req=0, imem_addr=RESET_PC, if_pc_read_data=RESET_PC, if_instruction=NOP_WORD,
//    stall_request_from_if=1.
//  imem_req = (state==S_REQ); imem_addr = pc; if_pc_read_data = pc;
//    if_instruction = valid ? inst_buf : NOP_WORD; stall_request_from_if = (state!=S_HOLD).
//  S_IDLE: -> S_REQ next cycle unconditionally (one dead cycle after reset); imem_ack ignored.
//  S_REQ: imem_ack=0 -> stay. imem_ack=1 -> inst_buf<=imem_rdata, valid<=1, -> S_HOLD. pc unchanged.
//  S_HOLD: stall[0]=1 -> hold all state. stall[0]=0 -> word consumed by IF/ID at this edge:
//    pc <= next_pc, valid<=0, -> S_REQ.
//  next_pc priority: branch_flag this cycle -> branch_target; else pend_flag -> pend_target
//    (pend_flag<=0); else pc+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0).
//  branch_flag arriving when not consuming (S_REQ, or S_HOLD with stall[0]=1): pend_flag<=1,
//    pend_target<=branch_target; a second pulse before use overwrites the first.
//  Delay slot: the word fetched/held when branch_flag arrives is always issued; target follows it.
//  Throughput: one instruction per 2 cycles minimum (zero-wait memory: ack in first S_REQ cycle).
//  Simultaneous branch_flag and consume in S_HOLD: redirect applied directly, pend not set.
//  Reset mid-fetch: request abandoned, imem_req low from next cycle; a late ack in S_IDLE is dropped.
//  branch_target[1:0] and pc[1:0] always 0; no misalignment exception generated here.
// TESTING
//  1. Reset, ack same cycle as req, stall=0: PCs 0,4,8,C presented; imem_req high every 2nd cycle.
//  2. Ack delayed 3 cycles: imem_addr stable at 0x4, stall_request_from_if=1 for 3 cycles, then 0.
//  3. stall[0]=1 for 4 cycles in S_HOLD: pc, if_instruction frozen; no new imem_req issued.
//  4. branch_flag (target 0x100) while fetching 0x8: word at 0x8 issued, next imem_addr=0x100.
//  5. branch_flag with stall[0]=1 in S_HOLD, then release: pend used, next fetch 0x100, pend cleared.
//  6. reset asserted while imem_req high, ack arrives next cycle: ack ignored, refetch RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, requests words from instruction
// memory and hands them to the IF/ID register, with delayed branches.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   stall[5:0]            stall vector; only stall[0] (IF/ID hold) is used
//   branch_flag           one-cycle redirect pulse from ID
//   branch_target         redirect address (low two bits ignored)
//   imem_req/imem_addr    fetch request, held with a stable address until ack
//   imem_ack/imem_rdata   memory response, data valid with ack
//   if_pc_read_data       PC of the word presented to IF/ID
//   if_instruction        presented word, NOP_WORD when none is held
//   stall_request_from_if high while IF has no word to hand over
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [5:0]  stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_pc_read_data,
    output logic [31:0] if_instruction,
    output logic        stall_request_from_if
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_HOLD
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst_buf;
    logic        valid;
    logic        pend_flag;
    logic [31:0] pend_target;

    logic        consume;
    logic [31:0] target;
    logic [31:0] next_pc;
    logic        unused_bits;

    assign target      = {branch_target[31:2], 2'b00};
    assign unused_bits = ^{stall[5:1], branch_target[1:0]};

    // IF/ID takes the held word at this edge.
    assign consume = (state == S_HOLD) && !stall[0];

    // A live pulse beats a stored one: it is the most recent redirect.
    always_comb begin
        next_pc = pc + 32'd4;
        if (branch_flag) begin
            next_pc = target;
        end else if (pend_flag) begin
            next_pc = pend_target;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            inst_buf    <= NOP_WORD;
            valid       <= 1'b0;
            pend_flag   <= 1'b0;
            pend_target <= 32'h0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state <= S_REQ;
                end
                S_REQ: begin
                    if (imem_ack) begin
                        inst_buf <= imem_rdata;
                        valid    <= 1'b1;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (!stall[0]) begin
                        pc    <= next_pc;
                        valid <= 1'b0;
                        state <= S_REQ;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            // Redirect is consumed with the delay-slot word, else parked.
            if (consume) begin
                pend_flag <= 1'b0;
            end else if (branch_flag) begin
                pend_flag   <= 1'b1;
                pend_target <= target;
            end
        end
    end

    assign imem_req              = (state == S_REQ);
    assign imem_addr             = pc;
    assign if_pc_read_data       = pc;
    assign if_instruction        = valid ? inst_buf : NOP_WORD;
    assign stall_request_from_if = (state != S_HOLD);

endmodule
